axis_rr_arbiter: RTL and testbench
==================================

Name: axis_rr_arbiter

Overview:
- Packet-aware round-robin arbiter that shares one AXI-Stream output between NUM_SRC AXI-Stream sources.
- Sits in front of a downstream axis_pipe stage or consumer.
- Locks the grant for a whole packet (until the tlast beat), registers the output, and tags each beat with its source index.

Parameters:
- NUM_SRC, 4, number of requesting sources (2..16).
- AXIS_WIDTH, 32, tdata width per source and on the output.
- ID_WIDTH, 2, width of m_axis_tid; must be >= clog2(NUM_SRC).

Ports:
- clk  input  1  single clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- s_axis_tvalid  input  NUM_SRC  per-source valid; bit i = source i.
- s_axis_tdata  input  NUM_SRC*AXIS_WIDTH  source i in bits [i*AXIS_WIDTH +: AXIS_WIDTH].
- s_axis_tlast  input  NUM_SRC  per-source end-of-packet.
- s_axis_tready  output  NUM_SRC  per-source ready; at most one bit high.
- m_axis_tvalid  output  1  output valid (registered).
- m_axis_tdata  output  AXIS_WIDTH  output data (registered).
- m_axis_tlast  output  1  output last (registered).
- m_axis_tid  output  ID_WIDTH  index of the source of the current beat (registered).
- m_axis_tready  input  1  downstream ready.

Behaviour:
- Reset state (reset low, async):
  - FSM = IDLE, grant = 0, rr_ptr = 0.
  - m_axis_tvalid = 0; m_axis_tdata = 0; m_axis_tlast = 0; m_axis_tid = 0.
  - s_axis_tready = all 0.
- Reset deassertion is synchronised by the integrator; the block only requires that reset is asynchronous on assertion.
- no_stall = ~m_axis_tvalid | m_axis_tready.
- FSM state IDLE:
  - s_axis_tready = 0.
  - If any s_axis_tvalid bit is set, pick the first set bit searching upward from rr_ptr, wrapping modulo NUM_SRC.
  - Register the pick as grant and go to BUSY.
  - No tvalid set: stay in IDLE.
- FSM state BUSY:
  - s_axis_tready[grant] = no_stall (combinational); all other bits 0.
  - On an accepted beat (s_axis_tvalid[grant] & s_axis_tready[grant]): load m_axis_tdata/tlast from source grant, set m_axis_tid = grant, set m_axis_tvalid = 1.
  - If the accepted beat has tlast = 1: go to IDLE and set rr_ptr = (grant + 1) mod NUM_SRC.
- Output valid update:
  - If no beat is accepted and m_axis_tready = 1: m_axis_tvalid <= 0.
  - Otherwise m_axis_tvalid holds.
  - Output registers change only when no_stall = 1.
- Latency and throughput:
  - Requester in IDLE at cycle 0 → grant at edge 1 → s_axis_tready high in cycle 1 → m_axis_tvalid high in cycle 2.
  - Within a packet: one beat per cycle while m_axis_tready stays high.
  - Exactly one idle arbitration cycle between packets.
- Granted source drops tvalid mid-packet: grant is held and no beat is emitted until the source resumes. No timeout.
- Non-granted sources asserting tvalid mid-packet: ignored until the packet's tlast is accepted.
- Single-beat packet (tlast on the first beat): BUSY lasts one accepted beat, then IDLE.
- Backpressure (m_axis_tvalid = 1, m_axis_tready = 0): s_axis_tready = 0; all output registers hold (AXI-Stream stability rule).
- Fairness: after source i finishes a packet, source i has the lowest priority in the next arbitration. No source is starved while others hold requests.
- Reset asserted mid-packet: the packet is abandoned, all outputs return to reset values immediately, and arbitration restarts from source 0.

Optional Feature:
- Macro: AXIS_ARB_PKTCNT_EN.
- Defined:
  - Adds output port pkt_count [15:0].
  - Counts packets completed on the output, i.e. cycles with m_axis_tvalid & m_axis_tready & m_axis_tlast.
  - Increments by 1 per completed packet; wraps 0xFFFF → 0x0000; resets to 0.
- Not defined: the port and the counter do not exist; all other behaviour is identical.

Test Plan:
- Single source: src1 sends a 3-beat packet A1,A2,A3 (tlast on A3), m_axis_tready = 1 → output A1,A2,A3 on consecutive cycles starting 2 cycles after first tvalid; m_axis_tid = 1; tlast only on A3.
- Round-robin order: srcs 0, 2, 3 each hold a 2-beat packet from cycle 0, rr_ptr = 0 → packets appear in order 0, 2, 3, with one bubble cycle between packets; next contest with src0 and src3 pending grants src0.
- Backpressure: m_axis_tready low for 4 cycles mid-packet → m_axis_tdata/tlast/tid held stable; s_axis_tready[grant] = 0 throughout; no beat lost or duplicated.
- Packet lock: src0 packet in progress, src1 asserts tvalid → s_axis_tready[1] stays 0 until src0's tlast beat is accepted; src1 granted next.
- Source gap: granted src2 drops tvalid for 3 cycles mid-packet → m_axis_tvalid falls after the current beat is taken; grant held; stream resumes with the correct data.
- Reset mid-packet (AXIS_ARB_PKTCNT_EN defined): after 2 completed packets pkt_count = 2; assert reset during the third packet → all outputs 0 and pkt_count = 0 in the same cycle; after release src0 is arbitrated first.

Source files
------------

// File: rtl/axis_rr_arbiter.sv
// Packet-locked round-robin arbiter merging NUM_SRC AXI-Stream sources onto one registered output.
// Optional feature macro AXIS_ARB_PKTCNT_EN adds pkt_count, a 16-bit count of completed output packets.
module axis_rr_arbiter #(
  parameter int NUM_SRC    = 4,
  parameter int AXIS_WIDTH = 32,
  parameter int ID_WIDTH   = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_SRC-1:0]            s_axis_tvalid,
  input  logic [NUM_SRC*AXIS_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_SRC-1:0]            s_axis_tlast,
  output logic [NUM_SRC-1:0]            s_axis_tready,
  output logic                          m_axis_tvalid,
  output logic [AXIS_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tlast,
  output logic [ID_WIDTH-1:0]           m_axis_tid,
`ifdef AXIS_ARB_PKTCNT_EN
  output logic [15:0]                   pkt_count,
`endif
  input  logic                          m_axis_tready
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]            state_r;
  logic [ID_WIDTH-1:0]   grant_r;
  logic [ID_WIDTH-1:0]   rr_ptr_r;
  logic                  m_valid_r;
  logic [AXIS_WIDTH-1:0] m_data_r;
  logic                  m_last_r;
  logic [ID_WIDTH-1:0]   m_id_r;

  logic                  no_stall_s;
  logic                  found_s;
  logic [ID_WIDTH-1:0]   pick_s;
  logic [NUM_SRC-1:0]    ready_s;
  logic                  accept_s;
  logic [AXIS_WIDTH-1:0] sel_data_s;
  logic                  sel_last_s;
  logic [ID_WIDTH-1:0]   next_ptr_s;

  assign no_stall_s = ~m_valid_r | m_axis_tready;

  // Rotating-priority pick: the requester closest above rr_ptr_r (with wrap) wins
  always_comb begin
    int  best_v;
    int  dist_v;
    logic take_v;
    best_v  = NUM_SRC;
    dist_v  = 0;
    take_v  = 1'b0;
    found_s = 1'b0;
    pick_s  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      dist_v  = (i + NUM_SRC - int'(rr_ptr_r)) % NUM_SRC;
      take_v  = s_axis_tvalid[i] & (dist_v < best_v);
      best_v  = take_v ? dist_v : best_v;
      pick_s  = take_v ? ID_WIDTH'(i) : pick_s;
      found_s = found_s | take_v;
    end
  end

  // Ready towards the granted source only, gated by output stall; mux of its beat
  always_comb begin
    ready_s    = '0;
    sel_data_s = '0;
    sel_last_s = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      ready_s[i] = (state_r == ST_BUSY) & (grant_r == ID_WIDTH'(i)) & no_stall_s;
      sel_data_s = sel_data_s
                 | ({AXIS_WIDTH{grant_r == ID_WIDTH'(i)}} & s_axis_tdata[i*AXIS_WIDTH +: AXIS_WIDTH]);
      sel_last_s = sel_last_s | ((grant_r == ID_WIDTH'(i)) & s_axis_tlast[i]);
    end
  end

  assign accept_s      = |(s_axis_tvalid & ready_s);
  assign s_axis_tready = ready_s;
  assign next_ptr_s    = (grant_r == ID_WIDTH'(NUM_SRC - 1)) ? '0 : grant_r + ID_WIDTH'(1);

  // Arbitration FSM: grant is locked from pick until the tlast beat is accepted
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= ST_IDLE;
      grant_r  <= '0;
      rr_ptr_r <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (found_s) begin
            grant_r <= pick_s;
            state_r <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (accept_s && sel_last_s) begin
            state_r  <= ST_IDLE;
            rr_ptr_r <= next_ptr_s;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Output register stage; a beat is only accepted when the stage is free or draining
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_valid_r <= 1'b0;
      m_data_r  <= '0;
      m_last_r  <= 1'b0;
      m_id_r    <= '0;
    end else if (accept_s) begin
      m_valid_r <= 1'b1;
      m_data_r  <= sel_data_s;
      m_last_r  <= sel_last_s;
      m_id_r    <= grant_r;
    end else if (m_axis_tready) begin
      m_valid_r <= 1'b0;
    end else begin
      m_valid_r <= m_valid_r;
    end
  end

  assign m_axis_tvalid = m_valid_r;
  assign m_axis_tdata  = m_data_r;
  assign m_axis_tlast  = m_last_r;
  assign m_axis_tid    = m_id_r;

`ifdef AXIS_ARB_PKTCNT_EN
  logic [15:0] pkt_cnt_r;

  // Completed output packets, wrapping at 16 bits
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pkt_cnt_r <= 16'h0000;
    end else if (m_valid_r && m_axis_tready && m_last_r) begin
      pkt_cnt_r <= pkt_cnt_r + 16'h0001;
    end else begin
      pkt_cnt_r <= pkt_cnt_r;
    end
  end

  assign pkt_count = pkt_cnt_r;
`endif

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Self-checking bench for axis_rr_arbiter: directed scenarios with literal timing plus randomized traffic
// checked every cycle against a behavioural model and a per-source beat scoreboard.
module tb_axis_rr_arbiter;

  localparam int N    = 4;
  localparam int W    = 32;
  localparam int IW   = 2;
  localparam int MAXB = 128;

  localparam int D2_ID[10]  = '{0, 0, 2, 2, 3, 3, 0, 0, 3, 3};
  localparam int D2_OFF[10] = '{2, 3, 5, 6, 8, 9, 11, 12, 14, 15};
  localparam int D3_OFF[4]  = '{2, 7, 8, 9};
  localparam int D4_ID[5]   = '{0, 0, 0, 1, 1};
  localparam int D4_OFF[5]  = '{2, 3, 4, 6, 7};
  localparam int D5_OFF[4]  = '{2, 3, 7, 8};

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    s_axis_tvalid;
  logic [N*W-1:0]  s_axis_tdata;
  logic [N-1:0]    s_axis_tlast;
  logic [N-1:0]    s_axis_tready;
  logic            m_axis_tvalid;
  logic [W-1:0]    m_axis_tdata;
  logic            m_axis_tlast;
  logic [IW-1:0]   m_axis_tid;
  logic            m_axis_tready;
`ifdef AXIS_ARB_PKTCNT_EN
  logic [15:0]     pkt_count;
`endif

  always #5 clk = ~clk;

  axis_rr_arbiter #(.NUM_SRC(N), .AXIS_WIDTH(W), .ID_WIDTH(IW)) dut (
    .clk           (clk),
    .reset         (reset),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tid    (m_axis_tid),
`ifdef AXIS_ARB_PKTCNT_EN
    .pkt_count     (pkt_count),
`endif
    .m_axis_tready (m_axis_tready)
  );

  int checks = 0;
  int passed = 0;
  int cyc    = 0;
  int t0     = 0;

  // source-side packet memories and progress
  logic [W-1:0] mem_d [N][MAXB];
  logic         mem_l [N][MAXB];
  int  len [N];
  int  pos [N];
  int  cons [N];
  bit  on [N];
  int  start_at [N];
  int  p_on, p_rdy;
  int  gap_src, gap_beat, gap_left;
  int  bp_lo, bp_hi;

  // behavioural model of the arbiter
  int           owner, ptr, o_id, m_pkts;
  bit           o_valid, o_last;
  logic [W-1:0] o_data;

  // downstream handshake log
  int           log_n;
  int           log_cyc [64];
  int           log_id  [64];
  logic [W-1:0] log_d   [64];
  bit           log_l   [64];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic model_reset();
    owner = -1; ptr = 0; o_id = 0; m_pkts = 0;
    o_valid = 1'b0; o_last = 1'b0; o_data = '0;
  endtask

  task automatic clear_src();
    for (int s = 0; s < N; s++) begin
      len[s] = 0; pos[s] = 0; cons[s] = 0; on[s] = 1'b0; start_at[s] = 0;
    end
    gap_src = -1; gap_beat = 0; gap_left = 0;
    bp_lo = -1; bp_hi = -2;
    p_on = 100; p_rdy = 100;
    log_n = 0;
  endtask

  task automatic load_pkt(input int s, input int n, input logic [W-1:0] base);
    for (int b = 0; b < n; b++) begin
      mem_d[s][len[s]] = base + W'(b);
      mem_l[s][len[s]] = (b == n - 1);
      len[s]++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    s_axis_tvalid = '0; s_axis_tlast = '0; s_axis_tdata = '0; m_axis_tready = 1'b0;
    clear_src();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // one clock cycle: check registered outputs, drive inputs, check ready, advance model on the edge
  task automatic step();
    logic [N-1:0]  rdy_exp;
    logic          cap_v, cap_l;
    logic [W-1:0]  cap_d;
    logic [IW-1:0] cap_id;
    bit            no_stall;
    int            idx;
    @(negedge clk);
    cyc++;
    chk("m_tvalid", m_axis_tvalid, o_valid);
    chk("m_tdata", m_axis_tdata, o_data);
    chk("m_tlast", m_axis_tlast, o_last);
    chk("m_tid", m_axis_tid, o_id);
`ifdef AXIS_ARB_PKTCNT_EN
    chk("pkt_count", pkt_count, m_pkts);
`endif
    cap_v = m_axis_tvalid; cap_d = m_axis_tdata; cap_l = m_axis_tlast; cap_id = m_axis_tid;
    for (int s = 0; s < N; s++) begin
      if (s == gap_src && gap_left > 0 && !on[s]) gap_left--;
      else if (!on[s] && pos[s] < len[s] && cyc >= start_at[s] && $urandom_range(99) < p_on) on[s] = 1'b1;
      s_axis_tvalid[s] = on[s];
      if (on[s]) begin
        s_axis_tdata[s*W +: W] = mem_d[s][pos[s]];
        s_axis_tlast[s]        = mem_l[s][pos[s]];
      end else begin
        s_axis_tdata[s*W +: W] = W'($urandom);
        s_axis_tlast[s]        = 1'($urandom);
      end
    end
    if (cyc >= bp_lo && cyc <= bp_hi) m_axis_tready = 1'b0;
    else m_axis_tready = ($urandom_range(99) < p_rdy);
    #1;
    rdy_exp = '0;
    if (owner >= 0 && (!o_valid || m_axis_tready)) rdy_exp[owner] = 1'b1;
    chk("s_tready", s_axis_tready, rdy_exp);
    if (cap_v && m_axis_tready) begin
      if (log_n < 64) begin
        log_cyc[log_n] = cyc; log_id[log_n] = int'(cap_id);
        log_d[log_n] = cap_d; log_l[log_n] = cap_l; log_n++;
      end
      if (cons[cap_id] < len[cap_id]) begin
        chk("sb_data", cap_d, mem_d[cap_id][cons[cap_id]]);
        chk("sb_last", cap_l, mem_l[cap_id][cons[cap_id]]);
        cons[cap_id]++;
      end else begin
        chk("sb_extra_beat", 1'b1, 1'b0);
      end
    end
    @(posedge clk);
    no_stall = !o_valid || m_axis_tready;
    if (o_valid && m_axis_tready && o_last) m_pkts = (m_pkts + 1) % 65536;
    if (owner < 0) begin
      for (int k = 0; k < N; k++) begin
        idx = (ptr + k) % N;
        if (owner < 0 && s_axis_tvalid[idx]) owner = idx;
      end
      if (m_axis_tready) o_valid = 1'b0;
    end else if (s_axis_tvalid[owner] && no_stall) begin
      o_valid = 1'b1;
      o_data  = mem_d[owner][pos[owner]];
      o_last  = mem_l[owner][pos[owner]];
      o_id    = owner;
      if (owner == gap_src && pos[owner] == gap_beat) gap_left = 3;
      pos[owner]++;
      on[owner] = 1'b0;
      if (o_last) begin
        ptr   = (owner + 1) % N;
        owner = -1;
      end
    end else if (m_axis_tready) begin
      o_valid = 1'b0;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    reset = 1'b1;
    s_axis_tvalid = '0; s_axis_tlast = '0; s_axis_tdata = '0; m_axis_tready = 1'b0;
    clear_src();
    model_reset();
    #2 reset = 1'b0;
    #1;
    chk("rst_tvalid", m_axis_tvalid, 1'b0);
    chk("rst_tdata", m_axis_tdata, 32'h0);
    chk("rst_tlast", m_axis_tlast, 1'b0);
    chk("rst_tid", m_axis_tid, 2'd0);
    chk("rst_tready", s_axis_tready, 4'h0);

    // single source, three beats
    do_reset();
    load_pkt(1, 3, 32'h0000_00A1);
    t0 = cyc + 1;
    run(8);
    chk("d1_count", log_n, 3);
    for (int i = 0; i < 3; i++) begin
      chk("d1_cycle", log_cyc[i] - t0, 2 + i);
      chk("d1_data", log_d[i], 32'h0000_00A1 + i);
      chk("d1_tid", log_id[i], 1);
      chk("d1_tlast", log_l[i], (i == 2));
    end

    // round-robin order 0,2,3 then 0 before 3
    do_reset();
    load_pkt(0, 2, 32'h100); load_pkt(2, 2, 32'h200); load_pkt(3, 2, 32'h300);
    load_pkt(0, 2, 32'h110); load_pkt(3, 2, 32'h310);
    t0 = cyc + 1;
    run(20);
    chk("d2_count", log_n, 10);
    for (int i = 0; i < 10; i++) begin
      chk("d2_tid", log_id[i], D2_ID[i]);
      chk("d2_cycle", log_cyc[i] - t0, D2_OFF[i]);
    end

    // downstream backpressure for 4 cycles mid-packet
    do_reset();
    load_pkt(1, 4, 32'hB0);
    t0 = cyc + 1;
    bp_lo = t0 + 3; bp_hi = t0 + 6;
    run(12);
    chk("d3_count", log_n, 4);
    for (int i = 0; i < 4; i++) begin
      chk("d3_cycle", log_cyc[i] - t0, D3_OFF[i]);
      chk("d3_data", log_d[i], 32'hB0 + i);
    end

    // packet lock: src1 waits for src0's tlast
    do_reset();
    load_pkt(0, 3, 32'hC0); load_pkt(1, 2, 32'hD0);
    t0 = cyc + 1;
    start_at[1] = t0 + 2;
    run(12);
    chk("d4_count", log_n, 5);
    for (int i = 0; i < 5; i++) begin
      chk("d4_tid", log_id[i], D4_ID[i]);
      chk("d4_cycle", log_cyc[i] - t0, D4_OFF[i]);
    end

    // granted source pauses 3 cycles mid-packet
    do_reset();
    load_pkt(2, 4, 32'hE0);
    gap_src = 2; gap_beat = 1;
    t0 = cyc + 1;
    run(12);
    chk("d5_count", log_n, 4);
    for (int i = 0; i < 4; i++) begin
      chk("d5_cycle", log_cyc[i] - t0, D5_OFF[i]);
      chk("d5_data", log_d[i], 32'hE0 + i);
    end

    // reset asserted during the third packet
    do_reset();
    load_pkt(0, 2, 32'h10); load_pkt(1, 2, 32'h20); load_pkt(2, 4, 32'h30);
    t0 = cyc + 1;
    run(10);
    chk("d6_model_pkts", m_pkts, 2);
`ifdef AXIS_ARB_PKTCNT_EN
    chk("d6_pkt_count", pkt_count, 16'd2);
`endif
    chk("d6_mid_valid", m_axis_tvalid, 1'b1);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("d6_rst_tvalid", m_axis_tvalid, 1'b0);
    chk("d6_rst_tdata", m_axis_tdata, 32'h0);
    chk("d6_rst_tlast", m_axis_tlast, 1'b0);
    chk("d6_rst_tid", m_axis_tid, 2'd0);
    chk("d6_rst_tready", s_axis_tready, 4'h0);
`ifdef AXIS_ARB_PKTCNT_EN
    chk("d6_rst_pkt_count", pkt_count, 16'd0);
`endif
    do_reset();
    load_pkt(3, 2, 32'h40); load_pkt(0, 2, 32'h50);
    t0 = cyc + 1;
    run(10);
    chk("d6_count", log_n, 4);
    chk("d6_first_tid", log_id[0], 0);
    chk("d6_first_cycle", log_cyc[0] - t0, 2);
    chk("d6_second_tid", log_id[2], 3);
    chk("d6_second_cycle", log_cyc[2] - t0, 5);

    // randomized traffic with gaps and backpressure, then drain
    do_reset();
    for (int s = 0; s < N; s++) begin
      while (len[s] < 40) load_pkt(s, $urandom_range(5, 1), W'($urandom));
    end
    p_on = 60; p_rdy = 65;
    run(300);
    p_rdy = 25;
    run(200);
    p_on = 100; p_rdy = 100;
    run(300);
    for (int s = 0; s < N; s++) chk("rand_drained", cons[s], len[s]);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
